// File: rtl/seq_pair_pkg.sv
// -----------------------------------------------------------------------------
// seq_pair_pkg
//   Shared definitions for the serial pair-stimulus transmitter.
//   - state_t            : transmitter FSM encoding (IDLE / SHIFT / DONE)
//   - SEQ_PAIR_DEFAULT_W : default word width, independent of any instance W
// -----------------------------------------------------------------------------
package seq_pair_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int SEQ_PAIR_DEFAULT_W = 8;

endpackage : seq_pair_pkg

// File: rtl/eq_pair_counter.sv
// -----------------------------------------------------------------------------
// eq_pair_counter
//   Counts adjacent equal bits in a serial stream that belongs to one word.
//   The previous bit is remembered so each new bit can be compared against it;
//   the first bit of a word has no predecessor and is never counted.
//
// Ports
//   clk      : rising-edge clock
//   res      : synchronous active-high reset (clears count and previous bit)
//   clr      : start of a new word (clears count and previous bit)
//   bit_in   : serial bit currently being transmitted
//   bit_en   : bit_in carries a word bit this cycle
//   first    : bit_in is bit index 0 of the word
//   eq_count : registered number of equal adjacent pairs seen so far
// -----------------------------------------------------------------------------
module eq_pair_counter
  import seq_pair_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr,
  input  logic          bit_in,
  input  logic          bit_en,
  input  logic          first,
  output logic [CW-1:0] eq_count
);

  logic          prev_r;
  logic [CW-1:0] count_r;

  // Previous-bit memory and pair count; count holds between words until clr.
  always_ff @(posedge clk) begin
    if (res) begin
      prev_r  <= 1'b0;
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      prev_r  <= 1'b0;
      count_r <= {CW{1'b0}};
    end else if (bit_en) begin
      prev_r <= bit_in;
      // A word of W bits holds at most W-1 pairs, so this never overflows.
      if (!first && (bit_in == prev_r)) begin
        count_r <= count_r + CW'(1'b1);
      end else begin
        count_r <= count_r;
      end
    end else begin
      prev_r  <= prev_r;
      count_r <= count_r;
    end
  end

  assign eq_count = count_r;

endmodule : eq_pair_counter

// File: rtl/seq_pair_tx.sv
// -----------------------------------------------------------------------------
// seq_pair_tx
//   Word-to-serial stimulus transmitter for the two-equal-bit sequence
//   detector. A word is accepted over a valid/ready handshake while IDLE,
//   shifted out one bit per clock in SHIFT, and a one-cycle DONE pulse follows
//   the last bit. Alongside, eq_pair_counter counts adjacent equal pairs so
//   the receiving side has a reference count.
//
//   Per word (accept on edge t): t+1..t+W SHIFT, t+W+1 DONE, t+W+2 IDLE.
//
// Parameters
//   W         : word width (W >= 2)
//   MSB_FIRST : 1 = bit W-1 leaves first, 0 = bit 0 leaves first
//
// Ports
//   clk        : rising-edge clock
//   res        : synchronous active-high reset, overrides load_valid
//   load_data  : word to transmit
//   load_valid : load_data is valid
//   load_ready : word can be accepted (IDLE, decoded from state)
//   sout       : serial bit to detector inp (registered)
//   sout_valid : sout carries a word bit (registered)
//   busy       : SHIFT or DONE (decoded from state)
//   done       : one-cycle pulse after the last bit (registered)
//   eq_count   : equal adjacent pairs of the last word (registered)
// -----------------------------------------------------------------------------
module seq_pair_tx
  import seq_pair_pkg::*;
#(
  parameter int W         = SEQ_PAIR_DEFAULT_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [W-1:0]         load_data,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 sout,
  output logic                 sout_valid,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(W)-1:0] eq_count
);

  localparam int             IW       = $clog2(W);
  localparam logic [IW-1:0]  LAST_IDX = IW'(W - 1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [W-1:0]  sreg_r;
  logic [W-1:0]  sreg_nxt_s;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_nxt_s;
  logic          sout_r;
  logic          sout_nxt_s;
  logic          sout_valid_r;
  logic          sout_valid_nxt_s;
  logic          done_r;
  logic          done_nxt_s;
  logic          accept_s;
  logic          first_s;

  // Bit that leaves next from a word held in transmit position.
  function automatic logic head_bit(input logic [W-1:0] word);
    if (MSB_FIRST) begin
      head_bit = word[W-1];
    end else begin
      head_bit = word[0];
    end
  endfunction

  // Word with its head bit removed, so the following bit becomes the head.
  function automatic logic [W-1:0] advance(input logic [W-1:0] word);
    if (MSB_FIRST) begin
      advance = {word[W-2:0], 1'b0};
    end else begin
      advance = {1'b0, word[W-1:1]};
    end
  endfunction

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s      = state_r;
    sreg_nxt_s       = sreg_r;
    idx_nxt_s        = idx_r;
    sout_nxt_s       = 1'b0;
    sout_valid_nxt_s = 1'b0;
    done_nxt_s       = 1'b0;
    accept_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_valid) begin
          // Bit 0 is presented on the accept edge; the register keeps the
          // remainder so each SHIFT edge only needs to pop the head.
          accept_s         = 1'b1;
          state_nxt_s      = SHIFT;
          sreg_nxt_s       = advance(load_data);
          idx_nxt_s        = {IW{1'b0}};
          sout_nxt_s       = head_bit(load_data);
          sout_valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = DONE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s      = SHIFT;
          idx_nxt_s        = idx_r + IW'(1'b1);
          sreg_nxt_s       = advance(sreg_r);
          sout_nxt_s       = head_bit(sreg_r);
          sout_valid_nxt_s = 1'b1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shift register, bit index and registered serial outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      sreg_r       <= {W{1'b0}};
      idx_r        <= {IW{1'b0}};
      sout_r       <= 1'b0;
      sout_valid_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      sreg_r       <= sreg_nxt_s;
      idx_r        <= idx_nxt_s;
      sout_r       <= sout_nxt_s;
      sout_valid_r <= sout_valid_nxt_s;
      done_r       <= done_nxt_s;
    end
  end

  // idx_r tracks the bit now on sout, so index 0 marks the word's first bit.
  assign first_s = (idx_r == {IW{1'b0}});

  eq_pair_counter #(
    .CW (IW)
  ) u_eq_pair_counter (
    .clk      (clk),
    .res      (res),
    .clr      (accept_s),
    .bit_in   (sout_r),
    .bit_en   (sout_valid_r),
    .first    (first_s),
    .eq_count (eq_count)
  );

  assign load_ready = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign sout       = sout_r;
  assign sout_valid = sout_valid_r;
  assign done       = done_r;

endmodule : seq_pair_tx

// File: tb/tb_seq_pair_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_pair_tx
//   Two transmitters (MSB-first and LSB-first) share one stimulus stream.
//   A reference process decides acceptance from its own busy timer and queues
//   the expected serial sequence, pair count and accept cycle; a monitor pops
//   and compares whenever a DUT presents bits or its done pulse.
// -----------------------------------------------------------------------------
module tb_seq_pair_tx;

  localparam int W  = 8;
  localparam int EW = $clog2(W);

  typedef struct {
    logic [W-1:0] seq;    // seq[k] = k-th transmitted bit
    int           eq;
    int           stamp;  // cycle number of the accept edge
  } exp_t;

  logic          clk = 1'b0;
  logic          res;
  logic [W-1:0]  load_data;
  logic          load_valid;
  logic [1:0]    rdy, sout, sv, bsy, dn;
  logic [EW-1:0] eq_a [2];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   busy_left = 0;
  bit   model_ready = 1'b1;
  bit   rst_evt = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t cur [2];
  bit   in_word [2];
  int   pos [2];
  int   last_eq [2];

  always #5 clk = ~clk;

  seq_pair_tx #(.W(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .res(res), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy[0]), .sout(sout[0]), .sout_valid(sv[0]), .busy(bsy[0]),
    .done(dn[0]), .eq_count(eq_a[0])
  );

  seq_pair_tx #(.W(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .res(res), .load_data(load_data), .load_valid(load_valid),
    .load_ready(rdy[1]), .sout(sout[1]), .sout_valid(sv[1]), .busy(bsy[1]),
    .done(dn[1]), .eq_count(eq_a[1])
  );

  task automatic chk(input string nm, input int d, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", nm, d, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input int d);
    tests++;
    fails++;
    $display("FAIL %s dut%0d cyc %0d", nm, d, cyc);
  endtask

  // Reference: expected serial order and pair count straight from the word.
  function automatic exp_t mk_exp(input logic [W-1:0] data, input int d, input int stamp);
    exp_t e;
    e.stamp = stamp;
    e.eq    = 0;
    for (int k = 0; k < W; k++) e.seq[k] = (d == 0) ? data[W-1-k] : data[k];
    for (int k = 1; k < W; k++) if (e.seq[k] == e.seq[k-1]) e.eq++;
    return e;
  endfunction

  // Reference timing: a word occupies the block for W+1 cycles after its accept.
  initial forever begin
    @(posedge clk);
    cyc++;
    rst_evt = res;
    if (res) begin
      busy_left = 0;
      q0.delete();
      q1.delete();
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (load_valid) begin
      q0.push_back(mk_exp(load_data, 0, cyc));
      q1.push_back(mk_exp(load_data, 1, cyc));
      busy_left = W + 1;
      acc_cnt++;
    end
    model_ready = (busy_left == 0);
  end

  // Monitor: sample on the falling edge, away from DUT updates.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst_evt) begin
        chk("rst_sout_valid", d, sv[d], 0);
        chk("rst_sout", d, sout[d], 0);
        chk("rst_done", d, dn[d], 0);
        chk("rst_eq_count", d, eq_a[d], 0);
        chk("rst_load_ready", d, rdy[d], 1);
        chk("rst_busy", d, bsy[d], 0);
        in_word[d] = 1'b0;
        pos[d]     = 0;
        last_eq[d] = 0;
      end else begin
        chk("load_ready", d, rdy[d], model_ready);
        chk("busy", d, bsy[d], !model_ready);
        if (sv[d]) begin
          if (!in_word[d]) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
              fail_now("valid_without_word", d);
            end else begin
              if (d == 0) cur[0] = q0.pop_front();
              else        cur[1] = q1.pop_front();
              in_word[d] = 1'b1;
              pos[d]     = 0;
            end
          end
          if (in_word[d]) begin
            if (pos[d] >= W) begin
              fail_now("too_many_bits", d);
            end else begin
              chk("bit_time", d, cyc, cur[d].stamp + pos[d]);
              chk("bit_value", d, sout[d], cur[d].seq[pos[d]]);
              pos[d]++;
            end
          end
        end else begin
          chk("idle_sout", d, sout[d], 0);
        end
        if (dn[d]) begin
          if (!in_word[d]) begin
            fail_now("done_without_word", d);
          end else begin
            chk("done_bits_sent", d, pos[d], W);
            chk("done_time", d, cyc, cur[d].stamp + W);
            chk("done_eq_count", d, eq_a[d], cur[d].eq);
            last_eq[d] = cur[d].eq;
            in_word[d] = 1'b0;
          end
        end else if (!sv[d] && model_ready) begin
          chk("eq_count_hold", d, eq_a[d], last_eq[d]);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a word and wait (bounded) until the reference accepts it.
  task automatic send(input logic [W-1:0] data, input bit hold);
    int n;
    int waited;
    load_data  = data;
    load_valid = 1'b1;
    n          = acc_cnt;
    waited     = 0;
    while (acc_cnt == n && waited < 4 * W) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (acc_cnt == n) fail_now("accept_timeout", 0);
    if (!hold) load_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    load_valid = 1'b0;
    res        = 1'b1;
    idle(1);
    res        = 1'b0;
  endtask

  initial begin
    int r;
    int waited;
    res        = 1'b1;
    load_valid = 1'b0;
    load_data  = {W{1'b0}};
    idle(3);
    res = 1'b0;
    idle(2);

    // Mixed word, then all-equal words, then alternating word.
    send(8'b1100_1010, 1'b0);
    idle(W + 3);
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    idle(W + 3);
    send(8'h55, 1'b0);
    idle(W + 3);

    // Back-to-back with valid held; data changes while the first word shifts.
    send(8'hF0, 1'b1);
    send(8'h0F, 1'b1);
    load_valid = 1'b0;
    load_data  = 8'h3C;
    idle(W + 3);

    // Reset while bit index 4 is on sout.
    send(8'hAA, 1'b0);
    idle(4);
    pulse_reset();
    idle(3);

    // Reset and load on the same edge.
    load_data  = 8'hC3;
    load_valid = 1'b1;
    res        = 1'b1;
    idle(1);
    res        = 1'b0;
    load_valid = 1'b0;
    idle(3);

    // Randomised traffic with occasional resets.
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 24);
      if (r == 0) begin
        send(W'($urandom), 1'b0);
        idle($urandom_range(0, W + 1));
        pulse_reset();
      end else begin
        send(W'($urandom), 1'($urandom_range(0, 1)));
        idle($urandom_range(0, 3));
      end
    end

    // Drain: every queued word must come out.
    load_valid = 1'b0;
    waited     = 0;
    while ((q0.size() + q1.size() + int'(in_word[0]) + int'(in_word[1])) != 0 && waited < 4 * W) begin
      idle(1);
      waited++;
    end
    chk("drain_outstanding", 0, q0.size() + q1.size() + int'(in_word[0]) + int'(in_word[1]), 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_seq_pair_tx
